// File: rtl/mac_feed_pkg.sv
// rtl/mac_feed_pkg.sv - shared widths, FSM state enum and FIFO entry type for the MAC operand feeder
package mac_feed_pkg;

  localparam int OPND_W = 8;
  localparam int ACC_W  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } feed_state_t;

  typedef struct packed {
    logic [OPND_W-1:0] a;
    logic [OPND_W-1:0] b;
    logic              last;
  } pair_entry_t;

endpackage

// File: rtl/mac_pair_fifo.sv
// rtl/mac_pair_fifo.sv - synchronous operand-pair FIFO, no same-cycle pass-through
module mac_pair_fifo
  import mac_feed_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        aclr,
  input  logic        push,
  input  logic        pop,
  input  pair_entry_t wr_entry,
  output pair_entry_t rd_entry,
  output logic        full,
  output logic        empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  pair_entry_t mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_entry = mem[rd_ptr[AW-1:0]];

  // Pointer advance; guarded so an over-push or over-pop is ignored.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop && !empty) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage write; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= wr_entry;
  end

endmodule

// File: rtl/mac_operand_feeder.sv
// rtl/mac_operand_feeder.sv - frames operand pairs into MAC clear/issue/done sequences; MAC_FEED_PERF_EN adds bubble_cnt
module mac_operand_feeder
  import mac_feed_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int LEN_W = 8
) (
  input  logic              clk,
  input  logic              aclr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OPND_W-1:0] in_a,
  input  logic [OPND_W-1:0] in_b,
  input  logic              in_last,
  output logic [OPND_W-1:0] ina,
  output logic [OPND_W-1:0] inb,
  output logic              acc_clr,
  output logic              frame_done,
  output logic [LEN_W-1:0]  frame_len
`ifdef MAC_FEED_PERF_EN
  ,
  output logic [LEN_W-1:0]  bubble_cnt
`endif
);

  localparam logic [LEN_W-1:0] LEN_MAX = '1;
  localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

  feed_state_t state;
  feed_state_t next_state;
  pair_entry_t wr_entry;
  pair_entry_t head;
  logic        fifo_full;
  logic        fifo_empty;
  logic        push;
  logic        pop;
  logic        last_q;

  assign in_ready = !fifo_full;
  assign push     = in_valid && in_ready;
  assign wr_entry = '{a: in_a, b: in_b, last: in_last};

  mac_pair_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .aclr     (aclr),
    .push     (push),
    .pop      (pop),
    .wr_entry (wr_entry),
    .rd_entry (head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // State register.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) state <= IDLE;
    else      state <= next_state;
  end

  // Next state plus pop decision. Outputs are registered, so the pair for a
  // RUN cycle is popped on the edge that enters that cycle.
  always_comb begin
    next_state = state;
    pop        = 1'b0;
    case (state)
      IDLE:    if (!fifo_empty) next_state = CLEAR;
      CLEAR:   next_state = RUN;
      RUN:     if (last_q) next_state = DONE;
      DONE:    next_state = fifo_empty ? IDLE : CLEAR;
      default: next_state = IDLE;
    endcase
    pop = (next_state == RUN) && !fifo_empty;
  end

  // Registered MAC-side outputs and the saturating issue counter.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      ina        <= '0;
      inb        <= '0;
      acc_clr    <= 1'b0;
      frame_done <= 1'b0;
      frame_len  <= '0;
      last_q     <= 1'b0;
    end else begin
      acc_clr    <= (next_state == CLEAR);
      frame_done <= (next_state == DONE);
      last_q     <= pop && head.last;
      ina        <= pop ? head.a : '0;
      inb        <= pop ? head.b : '0;
      if (next_state == CLEAR) frame_len <= '0;
      else if (pop && (frame_len != LEN_MAX)) frame_len <= frame_len + LEN_ONE;
    end
  end

`ifdef MAC_FEED_PERF_EN
  // Counts RUN cycles that carry a bubble because the FIFO ran dry.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      bubble_cnt <= '0;
    end else if (next_state == CLEAR) begin
      bubble_cnt <= '0;
    end else if ((next_state == RUN) && !pop && (bubble_cnt != LEN_MAX)) begin
      bubble_cnt <= bubble_cnt + LEN_ONE;
    end
  end
`endif

endmodule

// File: tb/tb_mac_operand_feeder.sv
// tb/tb_mac_operand_feeder.sv - scoreboard bench for mac_operand_feeder with a behavioural MAC and frame model
module tb_mac_operand_feeder;

  localparam int DEPTH   = 2;
  localparam int LEN_W   = 8;
  localparam int LEN_MAX = (1 << LEN_W) - 1;

  logic             clk;
  logic             aclr;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_a;
  logic [7:0]       in_b;
  logic             in_last;
  logic [7:0]       ina;
  logic [7:0]       inb;
  logic             acc_clr;
  logic             frame_done;
  logic [LEN_W-1:0] frame_len;
`ifdef MAC_FEED_PERF_EN
  logic [LEN_W-1:0] bubble_cnt;
`endif

  mac_operand_feeder #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .clk        (clk),
    .aclr       (aclr),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_last    (in_last),
    .ina        (ina),
    .inb        (inb),
    .acc_clr    (acc_clr),
    .frame_done (frame_done),
    .frame_len  (frame_len)
`ifdef MAC_FEED_PERF_EN
    ,
    .bubble_cnt (bubble_cnt)
`endif
  );

  typedef struct {
    int a;
    int b;
    bit last;
  } pair_t;

  typedef struct {
    int sum;
    int len;
  } frame_t;

  pair_t  pair_q[$];
  frame_t frame_q[$];
  int     done_log[$];

  int  tests = 0;
  int  fails = 0;
  int  cyc = 0;
  int  pushes = 0;
  int  issues = 0;
  bit  model_ready = 1'b1;
  int  acc_sum = 0;
  int  acc_len = 0;
  int  frame_first_push = 0;
  int  clr_cyc = 0;
  int  first_issue_cyc = 0;
  bit  first_pending = 1'b0;
  int  clr_cnt = 0;
  int  bub = 0;
  bit  in_frame = 1'b0;
  bit  prev_last = 1'b0;
  bit  prev_done = 1'b0;
  bit  prev_done_nonempty = 1'b0;
  int  last_done_len = 0;
  int  ready_lows = 0;
  logic [15:0] mac;

  function automatic void check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  function automatic int done_at(input int i);
    if (i < done_log.size()) return done_log[i];
    return -1;
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural accumulator: asynchronous clear, adds the product each edge.
  always @(posedge clk or posedge acc_clr or posedge aclr) begin
    if (aclr || acc_clr) mac <= 16'd0;
    else                 mac <= mac + ({8'd0, ina} * {8'd0, inb});
  end

  // Stimulus side of the scoreboard: record accepted pairs and expected frame results.
  always @(posedge clk) begin
    pair_t  p;
    frame_t f;
    cyc++;
    if (!aclr && in_valid && model_ready) begin
      p.a    = int'(in_a);
      p.b    = int'(in_b);
      p.last = in_last;
      if (acc_len == 0) frame_first_push = cyc;
      pair_q.push_back(p);
      pushes++;
      acc_sum = (acc_sum + p.a * p.b) & 32'hFFFF;
      acc_len++;
      if (p.last) begin
        f.sum = acc_sum;
        f.len = (acc_len > LEN_MAX) ? LEN_MAX : acc_len;
        frame_q.push_back(f);
        acc_sum = 0;
        acc_len = 0;
      end
    end
  end

  // Monitor: compares DUT outputs against the scoreboard away from the active edge.
  always @(negedge clk) begin
    pair_t  p;
    frame_t f;
    bit     issue;
    int     occ;
    if (aclr) begin
      check("rst_ina", int'(ina), 0);
      check("rst_inb", int'(inb), 0);
      check("rst_acc_clr", int'(acc_clr), 0);
      check("rst_frame_done", int'(frame_done), 0);
      check("rst_frame_len", int'(frame_len), 0);
      check("rst_in_ready", int'(in_ready), 1);
      pair_q.delete();
      frame_q.delete();
      pushes = 0;
      issues = 0;
      acc_sum = 0;
      acc_len = 0;
      model_ready = 1'b1;
      clr_cnt = 0;
      in_frame = 1'b0;
      prev_last = 1'b0;
      prev_done = 1'b0;
      prev_done_nonempty = 1'b0;
      first_pending = 1'b0;
      bub = 0;
    end else begin
      issue = (ina != 8'd0) || (inb != 8'd0);
      check("done_timing", int'(frame_done), int'(prev_last));
      if (prev_done) check("clear_after_done", int'(acc_clr), int'(prev_done_nonempty));
      if (acc_clr) begin
        check("clr_operands", int'(ina | inb), 0);
        check("clr_vs_done", int'(frame_done), 0);
        clr_cnt++;
        clr_cyc = cyc;
        in_frame = 1'b1;
        first_pending = 1'b1;
        bub = 0;
      end
      if (frame_done) begin
        check("done_operands", int'(ina | inb), 0);
        check("clr_per_frame", clr_cnt, 1);
        check("done_has_frame", int'(frame_q.size() > 0), 1);
        clr_cnt = 0;
        in_frame = 1'b0;
        if (frame_q.size() > 0) begin
          f = frame_q.pop_front();
          check("frame_sum", int'(mac), f.sum);
          check("frame_len", int'(frame_len), f.len);
`ifdef MAC_FEED_PERF_EN
          check("bubble_cnt", int'(bubble_cnt), bub);
`endif
          done_log.push_back(int'(mac));
          last_done_len = int'(frame_len);
        end
      end
      if (issue) begin
        issues++;
        check("issue_in_frame", int'(in_frame), 1);
        check("issue_has_pair", int'(pair_q.size() > 0), 1);
        if (pair_q.size() > 0) begin
          p = pair_q.pop_front();
          check("issue_a", int'(ina), p.a);
          check("issue_b", int'(inb), p.b);
          prev_last = p.last;
        end else begin
          prev_last = 1'b0;
        end
        if (first_pending) begin
          first_issue_cyc = cyc;
          first_pending = 1'b0;
        end
      end else begin
        prev_last = 1'b0;
        if (in_frame && !acc_clr && !frame_done && bub < LEN_MAX) bub++;
      end
      occ = pushes - issues;
      check("in_ready", int'(in_ready), int'(occ < DEPTH));
      model_ready = (occ < DEPTH);
      if (!in_ready) ready_lows++;
      prev_done = frame_done;
      prev_done_nonempty = frame_done && (occ > 0);
    end
  end

  task automatic push(input logic [7:0] a, input logic [7:0] b, input logic last);
    int guard;
    guard = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_last  = last;
    while (!in_ready && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 500) check("push_ready_timeout", int'(in_ready), 1);
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic wait_drain(input int limit);
    int n;
    n = 0;
    while ((frame_q.size() != 0 || pair_q.size() != 0) && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("drain", frame_q.size() + pair_q.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int len;
    aclr     = 1'b1;
    in_valid = 1'b0;
    in_a     = 8'd0;
    in_b     = 8'd0;
    in_last  = 1'b0;
    repeat (3) @(negedge clk);
    #2 aclr = 1'b0;
    repeat (2) @(negedge clk);

    // Two-pair frame from IDLE, including clear and first-issue latency.
    done_log.delete();
    push(8'd3, 8'd4, 1'b0);
    push(8'd5, 8'd6, 1'b1);
    idle(1);
    wait_drain(100);
    check("t1_clr_latency", clr_cyc - frame_first_push, 1);
    check("t1_issue_latency", first_issue_cyc - frame_first_push, 2);
    check("t1_sum", done_at(0), 42);
    check("t1_len", last_done_len, 2);

    // Single-pair frame at operand maximum.
    done_log.delete();
    push(8'd255, 8'd255, 1'b1);
    idle(1);
    wait_drain(100);
    check("t2_sum", done_at(0), 65025);
    check("t2_len", last_done_len, 1);

    // Back-to-back frames.
    done_log.delete();
    push(8'd1, 8'd2, 1'b1);
    push(8'd7, 8'd8, 1'b0);
    push(8'd2, 8'd2, 1'b1);
    idle(1);
    wait_drain(100);
    check("t3_first_sum", done_at(0), 2);
    check("t3_second_sum", done_at(1), 60);
    check("t3_len", last_done_len, 2);

    // Gapped input inside a frame.
    done_log.delete();
    push(8'd10, 8'd10, 1'b0);
    idle(3);
    push(8'd1, 8'd1, 1'b1);
    idle(1);
    wait_drain(100);
    check("t4_sum", done_at(0), 101);

    // Long frame: frame_len saturation, sum wrap and FIFO-full backpressure.
    for (int i = 0; i < 300; i++) begin
      push(8'($urandom_range(1, 255)), 8'($urandom_range(1, 255)), (i == 299));
    end
    idle(1);
    wait_drain(2000);
    check("t5_len_sat", last_done_len, LEN_MAX);
    check("t5_full_seen", int'(ready_lows > 0), 1);

    // Randomized frames with random gaps.
    for (int f = 0; f < 25; f++) begin
      len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++) begin
        push(8'($urandom_range(1, 255)), 8'($urandom_range(1, 255)), (i == len - 1));
        if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
      end
    end
    idle(1);
    wait_drain(2000);

    // Reset in the middle of a 4-pair frame.
    push(8'd9, 8'd1, 1'b0);
    push(8'd9, 8'd2, 1'b0);
    push(8'd9, 8'd3, 1'b0);
    push(8'd9, 8'd4, 1'b1);
    check("t7_mid_run", int'(issues > 0), 1);
    #2;
    in_valid = 1'b0;
    in_last  = 1'b0;
    aclr     = 1'b1;
    repeat (3) @(negedge clk);
    #2 aclr = 1'b0;
    done_log.delete();
    repeat (4) @(negedge clk);
    check("t7_no_clear", clr_cnt, 0);
    check("t7_no_issue", issues, 0);
    check("t7_no_done", done_log.size(), 0);
    push(8'd2, 8'd3, 1'b1);
    idle(1);
    wait_drain(100);
    check("t7_sum", done_at(0), 6);
    check("t7_len", last_done_len, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
